// File: rtl/filter_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : filter_mac_pipe
//  Purpose  : Pipelined kernel multiply-accumulate for the image filter path.
//             One window of TAPS unsigned pixels per beat is multiplied by a
//             programmable signed kernel, summed, normalised by a rounding
//             right shift and clamped to one output pixel.
//             Stages: S1 multiply, S2 adder tree, S3 shift/round/clamp.
//             Latency is 3 cycles; throughput is 1 beat/cycle when unstalled.
//  Ports    : clk, rst (async, active-high)
//             coef_we/coef_addr/coef_data : kernel coefficient write port
//             shift_we/shift_data         : normalisation shift write port
//             in_valid/in_ready/in_pix    : window input, valid/ready
//             out_valid/out_ready/out_pix : result output, valid/ready
//             out_sat                     : result was clamped this beat
//  Config   : FILTER_MAC_ABS_EN - negative normalised results are replaced by
//             their magnitude before the high clamp; out_sat then flags only
//             the high clamp.
//  Revision : 1.0 - initial release
// ============================================================================
module filter_mac_pipe #(
  parameter  int TAPS    = 9,
  parameter  int PIX_W   = 8,
  parameter  int COEF_W  = 8,
  parameter  int SHIFT_W = 4,
  localparam int ADDR_W  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  input  logic                     shift_we,
  input  logic [SHIFT_W-1:0]       shift_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAPS*PIX_W-1:0]    in_pix,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PIX_W-1:0]         out_pix,
  output logic                     out_sat
);

  localparam int PROD_W = PIX_W + 1 + COEF_W;
  localparam int SUM_W  = PROD_W + $clog2(TAPS);
  // One extra bit so the rounding increment can never wrap the sum.
  localparam int RND_W  = SUM_W + 1;

  localparam logic [ADDR_W:0]          TAPS_A  = (ADDR_W + 1)'(TAPS);
  localparam logic signed [RND_W-1:0]  PIX_MAX = RND_W'((1 << PIX_W) - 1);

  // --------------------------------------------------------------------------
  // Configuration state
  // --------------------------------------------------------------------------
  logic signed [COEF_W-1:0]  coef_q [TAPS];
  logic        [SHIFT_W-1:0] shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
      shift_q <= '0;
    end else begin
      if (coef_we && ({1'b0, coef_addr} < TAPS_A)) coef_q[coef_addr] <= coef_data;
      if (shift_we) shift_q <= shift_data;
    end
  end

  // --------------------------------------------------------------------------
  // Flow control: the whole pipe freezes while the output is blocked, so
  // bubbles are preserved and every stage keeps its contents.
  // --------------------------------------------------------------------------
  logic v1_q, v2_q, v3_q;
  logic stall, adv;

  assign stall     = v3_q & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign out_valid = v3_q;

  // --------------------------------------------------------------------------
  // S1: multiply. Products are formed from the coefficients live in the
  // accept cycle, so later writes cannot affect a beat already in flight.
  // --------------------------------------------------------------------------
  logic signed [PROD_W-1:0]  prod_d [TAPS];
  logic signed [PROD_W-1:0]  prod_q [TAPS];
  logic        [SHIFT_W-1:0] sh1_q;

  genvar g;
  for (g = 0; g < TAPS; g++) begin : g_mult
    logic signed [PROD_W-1:0] px_ext;
    logic signed [PROD_W-1:0] cf_ext;
    // Pixel is zero-extended by one bit to become a non-negative signed value.
    assign px_ext    = PROD_W'($signed({1'b0, in_pix[g*PIX_W +: PIX_W]}));
    assign cf_ext    = PROD_W'(coef_q[g]);
    assign prod_d[g] = px_ext * cf_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      sh1_q <= '0;
      for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      if (in_valid) begin
        sh1_q <= shift_q;
        for (int i = 0; i < TAPS; i++) prod_q[i] <= prod_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // S2: adder tree
  // --------------------------------------------------------------------------
  logic signed [SUM_W-1:0]   sum_d;
  logic signed [SUM_W-1:0]   sum_q;
  logic        [SHIFT_W-1:0] sh2_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < TAPS; i++) sum_d = sum_d + SUM_W'(prod_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q  <= 1'b0;
      sum_q <= '0;
      sh2_q <= '0;
    end else if (adv) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sum_q <= sum_d;
        sh2_q <= sh1_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S3: round half up, arithmetic shift, clamp
  // --------------------------------------------------------------------------
  logic signed [RND_W-1:0] rnd;
  logic signed [RND_W-1:0] rounded;
  logic        [PIX_W-1:0] pix_d;
  logic                    sat_d;
  logic        [PIX_W-1:0] out_pix_q;
  logic                    out_sat_q;

  always_comb begin
    rnd = '0;
    if (sh2_q != '0) rnd = RND_W'(1) << (sh2_q - SHIFT_W'(1));
    rounded = (RND_W'(sum_q) + rnd) >>> sh2_q;
  end

`ifdef FILTER_MAC_ABS_EN
  logic signed [RND_W-1:0] mag;

  always_comb begin
    mag   = rounded[RND_W-1] ? -rounded : rounded;
    pix_d = mag[PIX_W-1:0];
    sat_d = 1'b0;
    if (mag > PIX_MAX) begin
      pix_d = '1;
      sat_d = 1'b1;
    end
  end
`else
  always_comb begin
    pix_d = rounded[PIX_W-1:0];
    sat_d = 1'b0;
    if (rounded[RND_W-1]) begin
      pix_d = '0;
      sat_d = 1'b1;
    end else if (rounded > PIX_MAX) begin
      pix_d = '1;
      sat_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q      <= 1'b0;
      out_pix_q <= '0;
      out_sat_q <= 1'b0;
    end else if (adv) begin
      v3_q <= v2_q;
      if (v2_q) begin
        out_pix_q <= pix_d;
        out_sat_q <= sat_d;
      end
    end
  end

  assign out_pix = out_pix_q;
  assign out_sat = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_filter_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_filter_mac_pipe
//  Purpose  : Self-checking bench for filter_mac_pipe. Results retired by the
//             DUT are compared against an integer reference model evaluated
//             with the kernel/shift state in force when each beat is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_filter_mac_pipe;

  localparam int TAPS    = 9;
  localparam int PIX_W   = 8;
  localparam int COEF_W  = 8;
  localparam int SHIFT_W = 4;
  localparam int ADDR_W  = 4;
  localparam int WIN_W   = TAPS * PIX_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               coef_we;
  logic [ADDR_W-1:0]  coef_addr;
  logic [COEF_W-1:0]  coef_data;
  logic               shift_we;
  logic [SHIFT_W-1:0] shift_data;
  logic               in_valid;
  logic               in_ready;
  logic [WIN_W-1:0]   in_pix;
  logic               out_valid;
  logic               out_ready;
  logic [PIX_W-1:0]   out_pix;
  logic               out_sat;

  always #5 clk = ~clk;

  filter_mac_pipe #(
    .TAPS(TAPS), .PIX_W(PIX_W), .COEF_W(COEF_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .shift_we(shift_we), .shift_data(shift_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_sat(out_sat)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: kernel and shift as the block should currently hold them.
  int m_coef [TAPS];
  int m_shift;
  logic [PIX_W:0] exp_q [$];   // {sat, pix} predicted at accept time
  logic [PIX_W:0] got_q [$];   // {sat, pix} observed at retire time
  logic last_acc;

  function automatic logic [PIX_W:0] model(input logic [WIN_W-1:0] w);
    longint s;
    longint maxv;
    s    = 0;
    maxv = (longint'(1) << PIX_W) - 1;
    for (int i = 0; i < TAPS; i++) s += longint'(w[i*PIX_W +: PIX_W]) * longint'(m_coef[i]);
    if (m_shift > 0) s += longint'(1) << (m_shift - 1);
    s = s >>> m_shift;
`ifdef FILTER_MAC_ABS_EN
    if (s < 0) s = -s;
`endif
    if (s < 0)    return {1'b1, {PIX_W{1'b0}}};
    if (s > maxv) return {1'b1, {PIX_W{1'b1}}};
    return {1'b0, s[PIX_W-1:0]};
  endfunction

  function automatic logic [WIN_W-1:0] rand_win();
    logic [WIN_W-1:0] w;
    for (int i = 0; i < TAPS; i++) w[i*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
    return w;
  endfunction

  function automatic logic [WIN_W-1:0] flat_win(input logic [PIX_W-1:0] p);
    logic [WIN_W-1:0] w;
    for (int i = 0; i < TAPS; i++) w[i*PIX_W +: PIX_W] = p;
    return w;
  endfunction

  // One clock cycle. Entered and left at posedge+1. Handshakes are observed
  // at the falling edge, then the model state is advanced like the DUT's.
  task automatic step();
    #4;
    last_acc = in_valid && in_ready;
    if (last_acc) exp_q.push_back(model(in_pix));
    if (out_valid && out_ready) got_q.push_back({out_sat, out_pix});
    if (coef_we && int'(coef_addr) < TAPS) m_coef[coef_addr] = int'($signed(coef_data));
    if (shift_we) m_shift = int'(shift_data);
    @(posedge clk);
    #1;
    coef_we  = 1'b0;
    shift_we = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < TAPS; i++) m_coef[i] = 0;
    m_shift = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    coef_we   = 1'b0;
    shift_we  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = ADDR_W'(addr);
    coef_data = COEF_W'(val);
    step();
  endtask

  task automatic set_shift(input int s);
    shift_we   = 1'b1;
    shift_data = SHIFT_W'(s);
    step();
  endtask

  task automatic send(input logic [WIN_W-1:0] w);
    in_valid = 1'b1;
    in_pix   = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (got_q.size() < exp_q.size() && n < 30) begin
      step();
      n++;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    in_valid = 1'b0; coef_we = 1'b0; shift_we = 1'b0; out_ready = 1'b1;
    coef_addr = '0; coef_data = '0; shift_data = '0; in_pix = '0;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    do_reset();
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b expected 1", in_ready); end
    vectors++;
    if (out_pix !== '0) begin miscompares++; $display("FAIL rst_pix: got %0h expected 0", out_pix); end
    vectors++;
    if (out_sat !== 1'b0) begin miscompares++; $display("FAIL rst_sat: got %b expected 0", out_sat); end
  endtask

  task automatic test_identity();
    logic [WIN_W-1:0] w;
    int lat;
    do_reset();
    write_coef(4, 1);
    w = rand_win();
    w[4*PIX_W +: PIX_W] = 8'h80;
    send(w);
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    vectors++;
    if (lat != 3) begin miscompares++; $display("FAIL ident_latency: got %0d expected 3", lat); end
    vectors++;
    if ({out_sat, out_pix} !== 9'h080) begin
      miscompares++; $display("FAIL ident_value: got %0h expected 080", {out_sat, out_pix});
    end
    drain();
  endtask

  task automatic test_box_blur();
    logic [PIX_W:0] g;
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, 1);
    set_shift(3);
    send(flat_win(8'd200));
    drain();
    vectors++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      miscompares++; $display("FAIL blur_count: got %0d expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== {1'b0, 8'd225} || g !== exp_q.pop_front()) begin
        miscompares++; $display("FAIL blur_value: got %0h expected 0e1", g);
      end
    end
  endtask

  task automatic test_saturation();
    logic [PIX_W:0] g;
    logic [PIX_W:0] neg_exp;
`ifdef FILTER_MAC_ABS_EN
    neg_exp = {1'b0, 8'h5A};
`else
    neg_exp = {1'b1, 8'h00};
`endif
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, 127);
    send(flat_win(8'd255));
    for (int i = 0; i < TAPS; i++) write_coef(i, -1);
    send(flat_win(8'd10));
    drain();
    vectors++;
    if (got_q.size() != 2) begin
      miscompares++; $display("FAIL sat_count: got %0d expected 2", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== 9'h1FF || g !== exp_q.pop_front()) begin
        miscompares++; $display("FAIL sat_high: got %0h expected 1ff", g);
      end
      vectors++;
      g = got_q.pop_front();
      if (g !== neg_exp || g !== exp_q.pop_front()) begin
        miscompares++; $display("FAIL sat_neg: got %0h expected %0h", g, neg_exp);
      end
    end
  endtask

  task automatic test_rounding();
    logic [WIN_W-1:0] w;
    logic [PIX_W:0]   g;
    do_reset();
    write_coef(0, 5);
    set_shift(1);
    w = rand_win();
    w[0 +: PIX_W] = 8'd1;
    send(w);
    set_shift(0);
    send(w);
    drain();
    vectors++;
    if (got_q.size() != 2) begin
      miscompares++; $display("FAIL round_count: got %0d expected 2", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== 9'd3 || g !== exp_q.pop_front()) begin
        miscompares++; $display("FAIL round_sh1: got %0h expected 3", g);
      end
      vectors++;
      g = got_q.pop_front();
      if (g !== 9'd5 || g !== exp_q.pop_front()) begin
        miscompares++; $display("FAIL round_sh0: got %0h expected 5", g);
      end
    end
  endtask

  task automatic test_coef_update();
    logic [WIN_W-1:0] w;
    logic [PIX_W:0]   g;
    do_reset();
    write_coef(4, 1);
    w = rand_win();
    w[4*PIX_W +: PIX_W] = 8'h40;
    in_valid = 1'b1; in_pix = w;
    coef_we = 1'b1; coef_addr = 4'd4; coef_data = 8'd2;
    step();
    w[4*PIX_W +: PIX_W] = 8'h50;
    in_pix = w;
    step();
    drain();
    vectors++;
    if (got_q.size() != 2) begin
      miscompares++; $display("FAIL cupd_count: got %0d expected 2", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== 9'h040 || g !== exp_q.pop_front()) begin
        miscompares++; $display("FAIL cupd_old: got %0h expected 040", g);
      end
      vectors++;
      g = got_q.pop_front();
      if (g !== 9'h0A0 || g !== exp_q.pop_front()) begin
        miscompares++; $display("FAIL cupd_new: got %0h expected 0a0", g);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIN_W-1:0] w;
    logic [PIX_W:0]   g;
    logic [PIX_W-1:0] held;
    int sent, c, stalls;
    bit have_held;
    do_reset();
    write_coef(4, 1);
    w = rand_win();
    sent = 0; c = 0; stalls = 0; have_held = 0;
    while ((sent < 6 || got_q.size() < 6) && c < 40) begin
      out_ready = !(c >= 4 && c < 9);
      in_valid  = (sent < 6);
      w[4*PIX_W +: PIX_W] = PIX_W'(10 * sent + 1);
      in_pix    = w;
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready: got %b expected 0", in_ready); end
        if (have_held) begin
          vectors++;
          if (out_pix !== held) begin miscompares++; $display("FAIL bp_stable: got %0h expected %0h", out_pix, held); end
        end
        held = out_pix;
        have_held = 1;
      end
      step();
      if (last_acc) sent++;
      c++;
    end
    in_valid = 1'b0;
    vectors++;
    if (stalls != 5) begin miscompares++; $display("FAIL bp_stalls: got %0d expected 5", stalls); end
    vectors++;
    if (got_q.size() != 6) begin
      miscompares++; $display("FAIL bp_count: got %0d expected 6", got_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        vectors++;
        g = got_q.pop_front();
        if (g !== {1'b0, PIX_W'(10 * k + 1)} || g !== exp_q.pop_front()) begin
          miscompares++; $display("FAIL bp_order[%0d]: got %0h expected %0h", k, g, 10 * k + 1);
        end
      end
    end
  endtask

  task automatic test_random_stream();
    logic [PIX_W:0] g;
    logic [PIX_W:0] e;
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, int'($signed(8'($urandom))));
    set_shift($urandom_range(4, 10));
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pix    = rand_win();
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) begin
        coef_we   = 1'b1;
        coef_addr = ADDR_W'($urandom_range(0, 15));
        coef_data = COEF_W'($urandom);
      end
      if ($urandom_range(0, 19) == 0) begin
        shift_we   = 1'b1;
        shift_data = SHIFT_W'($urandom_range(0, 15));
      end
      step();
    end
    drain();
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL rand_beat: got %0h expected %0h", g, e); end
    end
  endtask

  task automatic test_reset_midflight();
    logic [WIN_W-1:0] w;
    logic [PIX_W:0]   g;
    do_reset();
    write_coef(4, 1);
    w = rand_win();
    w[4*PIX_W +: PIX_W] = 8'h80;
    in_valid = 1'b1; in_pix = w;
    step();
    step();
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_prefill: got %b expected 1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_drop: got %b expected 0", out_valid); end
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) step();
    vectors++;
    if (got_q.size() != 0) begin miscompares++; $display("FAIL mid_stale: got %0d results expected 0", got_q.size()); end
    // Kernel was cleared by reset, so any window now yields zero.
    send(w);
    drain();
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++; $display("FAIL mid_count: got %0d expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== 9'h000 || g !== exp_q.pop_front()) begin
        miscompares++; $display("FAIL mid_cleared: got %0h expected 000", g);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; coef_we = 1'b0; shift_we = 1'b0; out_ready = 1'b1;
    coef_addr = '0; coef_data = '0; shift_data = '0; in_pix = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_identity();
    test_box_blur();
    test_saturation();
    test_rounding();
    test_coef_update();
    test_backpressure();
    test_random_stream();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
